// File: rtl/elem_serializer.sv
// elem_serializer
//
// Accepts one packed WORD_W-bit word through a valid/ready handshake and emits
// its ELEM_W-bit elements one per cycle, LSB element first, through a second
// valid/ready handshake. An active + pending word buffer lets the next word be
// accepted while the current one streams, so back-to-back words leave no
// output bubble.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   in_data holds a word
//   in_ready   block can take a word this cycle (register-driven)
//   in_data    packed word; element i = in_data[i*ELEM_W +: ELEM_W]
//   out_valid  out_data holds an element
//   out_ready  consumer takes the element this cycle
//   out_data   current element
//   out_idx    index of the current element within its word
//   out_last   current element is the last of its word
//   busy       active or pending word held
module elem_serializer #(
  parameter int unsigned WORD_W = 144,
  parameter int unsigned ELEM_W = 8,
  localparam int unsigned N     = WORD_W / ELEM_W,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy
);

  logic              act_valid_q, act_valid_d;
  logic [WORD_W-1:0] act_word_q, act_word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pend_valid_q, pend_valid_d;
  logic [WORD_W-1:0] pend_word_q, pend_word_d;

  logic accept, pop, at_last, done;

  assign at_last   = (idx_q == IDX_W'(N - 1));
  assign in_ready  = !pend_valid_q;
  assign out_valid = act_valid_q;
  assign out_idx   = idx_q;
  assign out_last  = act_valid_q && at_last;
  assign busy      = act_valid_q | pend_valid_q;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign done   = pop && at_last;

  // Element select as an explicit mux so the index arithmetic stays in range.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (idx_q == IDX_W'(i)) begin
        out_data = act_word_q[i*ELEM_W +: ELEM_W];
      end
    end
  end

  always_comb begin
    act_valid_d  = act_valid_q;
    act_word_d   = act_word_q;
    idx_d        = idx_q;
    pend_valid_d = pend_valid_q;
    pend_word_d  = pend_word_q;

    if (pop) begin
      if (done) begin
        idx_d = '0;
        if (pend_valid_q) begin
          // Pending word takes over; in_ready is low here so no accept.
          act_word_d   = pend_word_q;
          pend_valid_d = 1'b0;
        end else if (accept) begin
          // Word offered on the last element goes straight to active.
          act_word_d = in_data;
        end else begin
          act_valid_d = 1'b0;
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (accept && !act_valid_q) begin
      act_word_d  = in_data;
      act_valid_d = 1'b1;
      idx_d       = '0;
    end

    if (accept && act_valid_q && !done) begin
      pend_word_d  = in_data;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_valid_q  <= 1'b0;
      act_word_q   <= '0;
      idx_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_word_q  <= '0;
    end else begin
      act_valid_q  <= act_valid_d;
      act_word_q   <= act_word_d;
      idx_q        <= idx_d;
      pend_valid_q <= pend_valid_d;
      pend_word_q  <= pend_word_d;
    end
  end

endmodule

// File: tb/tb_elem_serializer.sv
module tb_elem_serializer;

  localparam int unsigned WORD_W = 144;
  localparam int unsigned ELEM_W = 8;
  localparam int unsigned N      = WORD_W / ELEM_W;
  localparam int unsigned IDX_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              busy;

  elem_serializer #(
    .WORD_W(WORD_W),
    .ELEM_W(ELEM_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ELEM_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;
  bit   rand_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples at the falling edge, so values are stable between edges.
  logic              stalled = 1'b0;
  logic [ELEM_W-1:0] held_data;
  logic [IDX_W-1:0]  held_idx;
  logic              held_last;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(held_data));
        check("stall_idx", 32'(out_idx), 32'(held_idx));
        check("stall_last", 32'(out_last), 32'(held_last));
      end
      if (out_valid && out_ready) begin
        check("pop_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_idx", 32'(out_idx), 32'(e.idx));
          check("out_last", 32'(out_last), 32'(e.last));
        end
        pops++;
      end
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      held_idx  = out_idx;
      held_last = out_last;
      if (in_valid && in_ready) begin
        for (int i = 0; i < int'(N); i++) begin
          e.data = in_data[i*ELEM_W +: ELEM_W];
          e.idx  = IDX_W'(i);
          e.last = (i == int'(N) - 1);
          sb_q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [WORD_W-1:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    check("accept_in_time", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] w;
    for (int k = 0; k < int'(N); k++) w[k*ELEM_W +: ELEM_W] = ELEM_W'($urandom);
    return w;
  endfunction

  initial begin
    logic [WORD_W-1:0] w_inc, w_a, w_b, w_c;
    int cnt, cycles, pops0;
    bit sent_b;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single word, byte i = i
    for (int i = 0; i < int'(N); i++) w_inc[i*ELEM_W +: ELEM_W] = ELEM_W'(i);
    out_ready = 1'b1;
    pops0 = pops;
    send(w_inc);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data0", 32'(out_data), 32'h00);
    drain();
    check("single_pops", 32'(pops - pops0), 32'd18);
    check("single_valid_after", 32'(out_valid), 32'd0);

    // Back-to-back: B offered during A's last element
    w_a = rand_word();
    w_b = rand_word();
    send(w_a);
    cnt = 0;
    sent_b = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) cnt++;
      if (!sent_b && out_last) begin
        check("b2b_ready_at_last", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = w_b;
        sent_b   = 1'b1;
        tick();
        in_valid = 1'b0;
        check("b2b_no_bubble", 32'(out_valid), 32'd1);
        check("b2b_b_idx0", 32'(out_idx), 32'd0);
        check("b2b_b_data0", 32'(out_data), 32'(w_b[7:0]));
      end else begin
        tick();
      end
    end
    check("b2b_valid_cycles", 32'(cnt), 32'd36);
    drain();

    // Fill: A, B taken while stalled; C waits
    w_a = rand_word();
    w_b = rand_word();
    w_c = rand_word();
    out_ready = 1'b0;
    send(w_a);
    send(w_b);
    in_valid = 1'b1;
    in_data  = w_c;
    check("fill_busy", 32'(busy), 32'd1);
    check("fill_c_blocked", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    cycles = 0;
    while (!in_ready && cycles < 100) begin
      tick();
      cycles++;
    end
    check("fill_ready_return", 32'(cycles), 32'd18);
    tick();
    in_valid = 1'b0;
    drain();

    // Random out_ready over 20 random words
    rand_mode = 1'b1;
    for (int k = 0; k < 20; k++) send(rand_word());
    rand_mode = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset at element 7 with pending full
    w_a = rand_word();
    w_b = rand_word();
    out_ready = 1'b1;
    send(w_a);
    send(w_b);
    cycles = 0;
    while (out_idx != 5'd7 && cycles < 100) begin
      tick();
      cycles++;
    end
    check("mid_reached_idx7", 32'(out_idx), 32'd7);
    check("mid_pend_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    sb_q.delete();
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    send(rand_word());
    check("post_rst_idx0", 32'(out_idx), 32'd0);
    drain();

    // Reset held with in_valid high
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = rand_word();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_rst_ready", 32'(in_ready), 32'd1);
      check("hold_rst_valid", 32'(out_valid), 32'd0);
      check("hold_rst_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    tick();
    check("hold_rst_after", 32'(busy), 32'd0);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
